// File: rtl/cpu_step_gate_pkg.sv
// cpu_dbg_pkg: shared FSM encodings and defaults for the CPU step gate
// Contents:
//   STATE_W        width of the FSM state code
//   DB_CYCLES_DEF  default key debounce length in clk cycles
//   step_state_t   RUN / HALT / STEP state encodings
package cpu_dbg_pkg;
    localparam int STATE_W = 2;
    localparam logic [19:0] DB_CYCLES_DEF = 20'd500000;
    typedef enum logic [STATE_W-1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } step_state_t;
endpackage

// File: rtl/cpu_step_gate_key_debounce.sv
// key_debounce: synchronise a raw push-button and emit one pulse per stable press
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   key        raw asynchronous active-high button
//   key_pulse  one-clk pulse once key has been high for DB_CYCLES consecutive clks
module key_debounce
    import cpu_dbg_pkg::*;
#(
    parameter logic [19:0] DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_pulse
);
    logic        s1, s2, fired;
    logic [19:0] cnt;
    // fired blocks repeat pulses until the synchronised key is seen low again
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            fired     <= 1'b0;
            cnt       <= '0;
            key_pulse <= 1'b0;
        end else begin
            s1        <= key;
            s2        <= s1;
            key_pulse <= 1'b0;
            if (!s2) begin
                cnt   <= '0;
                fired <= 1'b0;
            end else if (!fired) begin
                if (cnt == DB_CYCLES - 20'd1) begin
                    key_pulse <= 1'b1;
                    fired     <= 1'b1;
                end else begin
                    cnt <= cnt + 20'd1;
                end
            end
        end
    end
endmodule

// File: rtl/cpu_step_gate.sv
// cpu_step_gate: turn divider ticks into gated single-cycle CPU enable pulses
// Optional feature macro: STEP_GATE_BREAKPOINT_EN (PC breakpoint with resume skip)
// Ports:
//   clk       system clock
//   rst       synchronous active-low reset
//   tick_in   divided-clock level from the clock divider
//   sw        sw[0]=1 run mode, 0 single-step mode; other bits unused
//   key1      raw push-button, asynchronous, active-high
//   pc_in     current CPU PC
//   bp_addr   breakpoint address
//   bp_en     breakpoint enable
//   cpu_en    one-clk advance pulse to the CPU
//   halted    high while in HALT
//   state     FSM state code
//   step_cnt  number of cpu_en pulses issued, wrapping
module cpu_step_gate
    import cpu_dbg_pkg::*;
#(
    parameter logic [19:0] DB_CYCLES = DB_CYCLES_DEF,
    parameter int          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_in,
    input  logic [15:0]        sw,
    input  logic               key1,
    input  logic [31:0]        pc_in,
    input  logic [31:0]        bp_addr,
    input  logic               bp_en,
    output logic               cpu_en,
    output logic               halted,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   step_cnt
);
    step_state_t cur, nxt;
    logic        tick_d, tick_pulse, key_pulse, en_n, bp_stop;
    logic        unused_ok;
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key (
        .clk      (clk),
        .rst      (rst),
        .key      (key1),
        .key_pulse(key_pulse)
    );
    assign tick_pulse = tick_in & ~tick_d;
    assign state      = cur;
`ifdef STEP_GATE_BREAKPOINT_EN
    logic skip_bp;
    // skip_bp lets a resume from a breakpoint step past the PC that stopped it
    assign bp_stop   = bp_en & (pc_in == bp_addr) & ~skip_bp;
    assign unused_ok = ^sw[15:1];
    always_ff @(posedge clk) begin
        if (!rst)
            skip_bp <= 1'b0;
        else if (cur == HALT && key_pulse && sw[0])
            skip_bp <= 1'b1;
        else if (cur == RUN && en_n)
            skip_bp <= 1'b0;
    end
`else
    assign bp_stop   = 1'b0;
    assign unused_ok = ^{sw[15:1], pc_in, bp_addr, bp_en};
`endif
    // A key press in HALT wins over a coincident tick, so that tick is never consumed
    always_comb begin
        nxt  = cur;
        en_n = 1'b0;
        case (cur)
            HALT: if (key_pulse) nxt = sw[0] ? RUN : STEP;
            RUN: begin
                if (!sw[0])
                    nxt = HALT;
                else if (tick_pulse) begin
                    if (bp_stop)
                        nxt = HALT;
                    else
                        en_n = 1'b1;
                end
            end
            STEP: begin
                if (tick_pulse) begin
                    en_n = 1'b1;
                    nxt  = HALT;
                end
            end
            default: nxt = HALT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur      <= HALT;
            tick_d   <= 1'b0;
            cpu_en   <= 1'b0;
            halted   <= 1'b1;
            step_cnt <= '0;
        end else begin
            cur      <= nxt;
            tick_d   <= tick_in;
            cpu_en   <= en_n;
            halted   <= (nxt == HALT);
            step_cnt <= step_cnt + CNT_W'(en_n);
        end
    end
endmodule
